// File: rtl/v2f_arith_pkg.sv
// Shared arithmetic definitions for the v2f wide-arithmetic library cells:
// limb width, the sequential-unit state encoding and a limb-count helper.
package v2f_arith_pkg;

  localparam int LIMB_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of LIMB_WIDTH limbs in a WIDTH-bit operand (WIDTH is a multiple of 32).
  function automatic int limb_count(input int width);
    return width / LIMB_WIDTH;
  endfunction

endpackage

// File: rtl/v2f_seq_divmod_wide_if.sv
// Operand/result bus of the sequential wide divider.
//
// Handshake: a transfer happens on a rising pos_clk edge where valid and
// ready are both high. The producer holds valid and its payload stable until
// that edge; ready may be any value and does not depend on valid. On the input
// side the divider is the consumer (in_ready), on the output side it is the
// producer (out_valid) and keeps out_* stable until out_ready is seen.
interface v2f_seq_divmod_wide_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_div_zero;

  // Side that supplies operands and consumes results.
  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_div_zero
  );

  // The divider itself.
  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_div_zero
  );
endinterface

// File: rtl/v2f_limb_sub.sv
// Combinational WIDTH-bit subtractor A-B assembled from 32-bit limbs with a
// ripple borrow, so no single arithmetic operator is wider than 33 bits.
module v2f_limb_sub
  import v2f_arith_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NUM_LIMBS = limb_count(WIDTH);

  for (genvar l = 0; l < NUM_LIMBS; l++) begin : g_limb
    logic                  borrow_in;
    logic                  borrow_out;
    logic [LIMB_WIDTH:0]   part;

    if (l == 0) begin : g_lsb
      assign borrow_in = 1'b0;
    end else begin : g_upper
      assign borrow_in = g_limb[l-1].borrow_out;
    end

    // 33-bit limb subtract; bit 32 of the result is the borrow into the next limb.
    assign part = {1'b0, a[l*LIMB_WIDTH +: LIMB_WIDTH]}
                - {1'b0, b[l*LIMB_WIDTH +: LIMB_WIDTH]}
                - {{LIMB_WIDTH{1'b0}}, borrow_in};

    assign diff[l*LIMB_WIDTH +: LIMB_WIDTH] = part[LIMB_WIDTH-1:0];
    assign borrow_out = part[LIMB_WIDTH];
  end

  assign borrow = g_limb[NUM_LIMBS-1].borrow_out;

endmodule

// File: rtl/v2f_seq_divmod_wide.sv
// Multi-cycle unsigned restoring divider for WIDTH-bit operands
// (WIDTH a multiple of 32, >= 64). ITER_PER_CYCLE shift-subtract steps are
// chained combinationally per clock (must divide WIDTH). Divide by zero
// returns quotient all-ones, remainder = dividend and raises out_div_zero.
module v2f_seq_divmod_wide
  import v2f_arith_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic                   pos_clk,
  input  logic                   pos_arst,
  v2f_seq_divmod_wide_if.slave   bus,
  output state_t                 dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] ITER_C  = CW'(ITER_PER_CYCLE);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] step_r;

  // Chain of restoring steps. The remainder is carried as WIDTH bits between
  // steps because it is always below the divisor; the shifted value gets one
  // guard bit, and a set guard bit means the subtraction cannot borrow.
  for (genvar i = 0; i < ITER_PER_CYCLE; i++) begin : g_step
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             take;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] q_out;

    if (i == 0) begin : g_first
      assign r_in = r_reg;
      assign q_in = q_reg;
    end else begin : g_next
      assign r_in = g_step[i-1].r_out;
      assign q_in = g_step[i-1].q_out;
    end

    assign r_shift = {r_in, q_in[WIDTH-1]};

    v2f_limb_sub #(
      .WIDTH (WIDTH)
    ) u_sub (
      .a      (r_shift[WIDTH-1:0]),
      .b      (divisor_reg),
      .diff   (diff),
      .borrow (borrow)
    );

    assign take  = r_shift[WIDTH] | ~borrow;
    assign r_out = take ? diff : r_shift[WIDTH-1:0];
    assign q_out = {q_in[WIDTH-2:0], take};
  end

  assign step_q   = g_step[ITER_PER_CYCLE-1].q_out;
  assign step_r   = g_step[ITER_PER_CYCLE-1].r_out;
  assign cnt_next = cnt + ITER_C;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_reg       <= '0;
      r_reg       <= '0;
      divisor_reg <= '0;
      cnt         <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            q_reg       <= bus.in_dividend;
            divisor_reg <= bus.in_divisor;
            r_reg       <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            if (bus.in_divisor == '0) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              quot_q      <= '1;
              rem_q       <= bus.in_dividend;
              div_zero_q  <= 1'b1;
            end else begin
              state      <= CALC;
              div_zero_q <= 1'b0;
            end
          end
        end
        CALC: begin
          q_reg <= step_q;
          r_reg <= step_r;
          cnt   <= cnt_next;
          if (cnt_next == WIDTH_C) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            quot_q      <= step_q;
            rem_q       <= step_r;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_quotient  = quot_q;
  assign bus.out_remainder = rem_q;
  assign bus.out_div_zero  = div_zero_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_v2f_seq_divmod_wide.sv
// Bench for v2f_seq_divmod_wide: one instance with one step per clock and
// one with four, fed identical operands. Expected quotient/remainder come
// from plain / and % on 64-bit values; latencies from WIDTH/ITER_PER_CYCLE.
module tb_v2f_seq_divmod_wide;
  import v2f_arith_pkg::*;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic pos_clk = 1'b0;
  logic pos_arst;
  always #5 pos_clk = ~pos_clk;

  v2f_seq_divmod_wide_if #(.WIDTH(W)) if1 ();
  v2f_seq_divmod_wide_if #(.WIDTH(W)) if4 ();
  state_t dbg1;
  state_t dbg4;

  v2f_seq_divmod_wide #(.WIDTH(W), .ITER_PER_CYCLE(1)) dut1 (
    .pos_clk   (pos_clk),
    .pos_arst  (pos_arst),
    .bus       (if1),
    .dbg_state (dbg1)
  );

  v2f_seq_divmod_wide #(.WIDTH(W), .ITER_PER_CYCLE(4)) dut4 (
    .pos_clk   (pos_clk),
    .pos_arst  (pos_arst),
    .bus       (if4),
    .dbg_state (dbg4)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned divide with the divide-by-zero convention.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if1.in_valid = v; if1.in_dividend = a; if1.in_divisor = b;
    if4.in_valid = v; if4.in_dividend = a; if4.in_divisor = b;
  endtask

  task automatic set_out_ready(input logic r);
    if1.out_ready = r;
    if4.out_ready = r;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready1"},  W'(if1.in_ready), 1);
    check({tag, "_in_ready4"},  W'(if4.in_ready), 1);
    check({tag, "_out_valid1"}, W'(if1.out_valid), 0);
    check({tag, "_out_valid4"}, W'(if4.out_valid), 0);
    check({tag, "_quot1"},      if1.out_quotient, 0);
    check({tag, "_rem4"},       if4.out_remainder, 0);
    check({tag, "_dz1"},        W'(if1.out_div_zero), 0);
    check({tag, "_state1"},     W'(dbg1), W'(IDLE));
    check({tag, "_state4"},     W'(dbg4), W'(IDLE));
  endtask

  // One division on both instances: accept, wait for each result, hold it
  // under backpressure for `hold` cycles, then hand it off.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq, er, sq, sr;
    logic edz;
    int lat1, lat4;
    bit rdy_ok, stable;
    model(a, b, eq, er, edz);
    exp_q.push_back(eq);
    exp_q.push_back(er);

    @(negedge pos_clk);
    check("accept_ready1", W'(if1.in_ready), 1);
    check("accept_ready4", W'(if4.in_ready), 1);
    drive_in(1'b1, a, b);
    @(posedge pos_clk); #1;
    drive_in(1'b0, rnd64(), rnd64());

    lat1 = 0; lat4 = 0; rdy_ok = 1'b1;
    for (int c = 1; c <= 100 && (lat1 == 0 || lat4 == 0); c++) begin
      if ($urandom_range(0, 3) == 0) drive_in(1'b1, rnd64(), rnd64());
      else drive_in(1'b0, rnd64(), rnd64());
      @(posedge pos_clk); #1;
      if (lat1 == 0) begin
        if (if1.out_valid) lat1 = c;
        else if (if1.in_ready) rdy_ok = 1'b0;
      end
      if (lat4 == 0) begin
        if (if4.out_valid) lat4 = c;
        else if (if4.in_ready) rdy_ok = 1'b0;
      end
    end

    sq = exp_q.pop_front();
    sr = exp_q.pop_front();
    check("latency1", W'(lat1), (b == 0) ? 1 : W);
    check("latency4", W'(lat4), (b == 0) ? 1 : W / 4);
    check("busy_in_ready_low", W'(rdy_ok), 1);
    check("quot1", if1.out_quotient, sq);
    check("rem1",  if1.out_remainder, sr);
    check("dz1",   W'(if1.out_div_zero), W'(edz));
    check("quot4", if4.out_quotient, sq);
    check("rem4",  if4.out_remainder, sr);
    check("dz4",   W'(if4.out_div_zero), W'(edz));

    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      drive_in(1'b1, rnd64(), rnd64());
      @(posedge pos_clk); #1;
      if (!(if1.out_valid && !if1.in_ready && if1.out_quotient == sq &&
            if1.out_remainder == sr && if1.out_div_zero == edz)) stable = 1'b0;
      if (!(if4.out_valid && !if4.in_ready && if4.out_quotient == sq &&
            if4.out_remainder == sr && if4.out_div_zero == edz)) stable = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", W'(stable), 1);

    // Handoff edge with a competing in_valid that must not be accepted.
    drive_in(1'b1, rnd64(), rnd64());
    set_out_ready(1'b1);
    @(posedge pos_clk); #1;
    set_out_ready(1'b0);
    drive_in(1'b0, rnd64(), rnd64());
    check("handoff_valid1", W'(if1.out_valid), 0);
    check("handoff_valid4", W'(if4.out_valid), 0);
    check("handoff_ready1", W'(if1.in_ready), 1);
    check("handoff_state4", W'(dbg4), W'(IDLE));
    check("handoff_state1", W'(dbg1), W'(IDLE));
    check("kept_quot1", if1.out_quotient, sq);
    check("kept_rem4",  if4.out_remainder, sr);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] a, b;
    pos_arst = 1'b1;
    drive_in(1'b0, '0, '0);
    set_out_ready(1'b0);
    #12;
    check_idle_reset("reset");
    @(negedge pos_clk);
    pos_arst = 1'b0;

    do_op(64'd100, 64'd7, 0);
    do_op(64'h8000_0000_0000_0000, 64'd3, 0);
    do_op(64'h1234, 64'd0, 0);
    do_op(64'd5, 64'd9, 1);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    do_op(64'd100, 64'd7, 5);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(64'h0000_0001_0000_0000, 64'hFFFF_FFFF, 2);

    // Reset in the middle of a calculation.
    @(negedge pos_clk);
    drive_in(1'b1, 64'd100, 64'd7);
    @(posedge pos_clk); #1;
    drive_in(1'b0, '0, '0);
    repeat (29) @(posedge pos_clk);
    #1;
    check("mid_calc_state1", W'(dbg1), W'(CALC));
    #2 pos_arst = 1'b1;
    #1;
    check_idle_reset("arst");
    @(negedge pos_clk);
    pos_arst = 1'b0;
    do_op(64'd100, 64'd7, 0);

    for (int n = 0; n < 12; n++) begin
      a = rnd64();
      case ($urandom_range(0, 3))
        0: b = rnd64();
        1: b = W'($urandom_range(1, 1000));
        2: b = '0;
        default: b = rnd64() >> $urandom_range(0, 63);
      endcase
      do_op(a, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
